// File: rtl/mii_rx_deframer.sv
// MII receive deframer: strips preamble/SFD from an MII nibble stream and
// emits assembled frame bytes with first/last markers and error status.
// A one-byte holding register lets the final byte be tagged byte_last when
// the frame ends.
// Optional FCS check is compiled in when MII_RX_DEFRAMER_FCS_EN is defined;
// otherwise fcs_err is tied to 0 and no CRC logic exists.
module mii_rx_deframer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic       valid,
    input  logic [3:0] data,
    input  logic       err,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_first,
    output logic       byte_last,
    output logic       frame_err,
    output logic       fcs_err
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_PREAMBLE = 2'd1;
    localparam logic [1:0] S_DATA     = 2'd2;
    localparam logic [1:0] S_DROP     = 2'd3;

    logic [1:0] state;
    logic       nib_hi;         // next DATA nibble is the high half of a byte
    logic [3:0] low_nib;
    logic [7:0] hold_byte;
    logic       hold_full;
    logic       first_pending;  // nothing emitted yet in this frame
    logic       err_seen;
    logic [7:0] new_byte;
    logic       enter_data;
    logic       emit;
    logic       emit_last;

    assign new_byte   = {data, low_nib};
    assign enter_data = ce && (state == S_PREAMBLE) && valid && !err && (data == 4'hD);

    // Decide whether this ce edge releases the held byte, and whether it ends the frame
    always_comb begin
        emit      = 1'b0;
        emit_last = 1'b0;
        if (ce && (state == S_DATA)) begin
            if (valid) begin
                emit = nib_hi && hold_full;
            end else if (hold_full) begin
                emit      = 1'b1;
                emit_last = 1'b1;
            end
        end
    end

    // Frame state machine, nibble assembly and holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            nib_hi        <= 1'b0;
            low_nib       <= 4'h0;
            hold_byte     <= 8'h00;
            hold_full     <= 1'b0;
            first_pending <= 1'b0;
            err_seen      <= 1'b0;
        end else if (ce) begin
            case (state)
                S_IDLE: begin
                    if (valid) begin
                        state <= (data == 4'h5 && !err) ? S_PREAMBLE : S_DROP;
                    end
                end
                S_PREAMBLE: begin
                    if (!valid) begin
                        state <= S_IDLE;
                    end else if (enter_data) begin
                        state         <= S_DATA;
                        nib_hi        <= 1'b0;
                        hold_full     <= 1'b0;
                        first_pending <= 1'b1;
                        err_seen      <= 1'b0;
                    end else if (err || data != 4'h5) begin
                        state <= S_DROP;
                    end
                end
                S_DATA: begin
                    if (valid) begin
                        err_seen <= err_seen | err;
                        if (!nib_hi) begin
                            low_nib <= data;
                            nib_hi  <= 1'b1;
                        end else begin
                            hold_byte <= new_byte;
                            hold_full <= 1'b1;
                            nib_hi    <= 1'b0;
                            if (hold_full) begin
                                first_pending <= 1'b0;
                            end
                        end
                    end else begin
                        state     <= S_IDLE;
                        hold_full <= 1'b0;
                        nib_hi    <= 1'b0;
                    end
                end
                default: begin
                    if (!valid) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Registered byte outputs; flags are only high during an emission pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_data  <= 8'h00;
            byte_valid <= 1'b0;
            byte_first <= 1'b0;
            byte_last  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= emit;
            byte_first <= emit && first_pending;
            byte_last  <= emit_last;
            frame_err  <= emit_last && (err_seen || nib_hi);
            if (emit) begin
                byte_data <= hold_byte;
            end
        end
    end

`ifdef MII_RX_DEFRAMER_FCS_EN
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    logic [31:0] crc_q;

    // Reflected CRC-32 update for one byte, LSB first
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) begin
                r = (r >> 1) ^ 32'hEDB88320;
            end else begin
                r = r >> 1;
            end
        end
        return r;
    endfunction

    // Running CRC over every completed DATA byte; good frames leave the magic residue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q   <= 32'hFFFFFFFF;
            fcs_err <= 1'b0;
        end else begin
            fcs_err <= emit_last && (crc_q != CRC_RESIDUE);
            if (enter_data) begin
                crc_q <= 32'hFFFFFFFF;
            end else if (ce && (state == S_DATA) && valid && nib_hi) begin
                crc_q <= crc_byte(crc_q, new_byte);
            end
        end
    end
`else
    assign fcs_err = 1'b0;
`endif

endmodule
